// File: rtl/mitchell_pkg.sv
// Shared definitions for the Mitchell log multiplier.
// The LOD/log encoder and the antilog converter both take their default
// operand format from here, so the two ends of the datapath agree on it.
//   CHAR_W_DFLT : characteristic (integer log) width
//   FRAC_W_DFLT : mantissa fraction width
//   OUT_W_DFLT  : linear result width
//   antilog_state_t : antilog converter FSM states
package mitchell_pkg;

  localparam int CHAR_W_DFLT = 5;
  localparam int FRAC_W_DFLT = 15;
  localparam int OUT_W_DFLT  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } antilog_state_t;

endpackage

// File: rtl/mitchell_antilog_round_sat.sv
// antilog_round_sat: combinational round-half-up with saturation.
// Adds the first dropped fraction bit to the truncated result; an all-ones
// result is left alone so the increment can never wrap to zero.
//   trunc     : truncated linear result
//   round_bit : most significant discarded fraction bit
//   res       : rounded, saturated result
module antilog_round_sat #(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0] trunc,
  input  logic             round_bit,
  output logic [OUT_W-1:0] res
);

  assign res = (&trunc) ? trunc : trunc + OUT_W'(round_bit);

endmodule

// File: rtl/mitchell_antilog.sv
// mitchell_antilog: log-to-linear converter, back end of the Mitchell
// multiplier. Computes (1 + f/2^FRAC_W) * 2^k by shifting an accumulator
// one bit per cycle, then presents the integer part of the result.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   in_zero               : operand is zero, char/frac ignored
//   in_char / in_frac     : characteristic k and fractional mantissa f
//   out_valid / out_ready : result handshake, result held until taken
//   out_data              : linear result
//   busy                  : FSM not in IDLE
//
// Build option: define MITCHELL_ANTILOG_ROUND_EN to round half up instead of
// truncating (zero and saturated results are never rounded).
module mitchell_antilog
  import mitchell_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DFLT,
  parameter int FRAC_W = FRAC_W_DFLT,
  parameter int OUT_W  = OUT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_zero,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  localparam int ACC_W = OUT_W + FRAC_W;

  antilog_state_t    state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CHAR_W-1:0] cnt;
  logic [OUT_W-1:0]  trunc;
  logic [OUT_W-1:0]  res;
  logic              accept;
  logic              sat;

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Characteristics at or beyond the output width cannot be represented.
  assign sat = 32'(in_char) >= 32'(OUT_W);

  // Value the accumulator takes at the coming edge; the result is taken
  // from it so out_data is registered in the same cycle DONE is entered.
  always_comb begin
    acc_nxt = acc << 1;
    if (state == IDLE) acc_nxt = ACC_W'({1'b1, in_frac});
  end

  assign trunc = acc_nxt[ACC_W-1:FRAC_W];

`ifdef MITCHELL_ANTILOG_ROUND_EN
  antilog_round_sat #(.OUT_W(OUT_W)) u_round_sat (
    .trunc     (trunc),
    .round_bit (acc_nxt[FRAC_W-1]),
    .res       (res)
  );
`else
  assign res = trunc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= in_char;
            if (in_zero) begin
              out_data <= '0;
              state    <= DONE;
            end else if (sat) begin
              out_data <= '1;
              state    <= DONE;
            end else if (in_char == '0) begin
              out_data <= res;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - CHAR_W'(1);
          if (cnt == CHAR_W'(1)) begin
            out_data <= res;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mitchell_antilog.sv
// Testbench for mitchell_antilog. Directed cases from the block's intended
// behaviour plus randomized operands; a scoreboard queue holds the expected
// value and the cycle out_valid must rise, and a monitor checks each result,
// its hold stability under backpressure and the return to ready.
// CHAR_W is widened to 6 so saturating characteristics can be driven.
module tb_mitchell_antilog;

  localparam int CHAR_W = 6;
  localparam int FRAC_W = 15;
  localparam int OUT_W  = 32;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               rise;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_zero = 1'b0;
  logic [CHAR_W-1:0] in_char = '0;
  logic [FRAC_W-1:0] in_frac = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   bp_mode = 1'b0;
  bit   rdy_rand = 1'b0;

  mitchell_antilog #(.CHAR_W(CHAR_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_zero   (in_zero),
    .in_char   (in_char),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer: random or stalled readiness, changed just after each edge.
  always @(posedge clk) begin
    #1;
    if (bp_mode)       out_ready = 1'b0;
    else if (rdy_rand) out_ready = ($urandom_range(0, 99) < 70);
    else               out_ready = 1'b1;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: real-valued (1 + f/2^FRAC_W) * 2^k, truncated or rounded half up.
  function automatic longint unsigned model(input bit z, input int k, input int f);
    longint unsigned v, r, maxv;
    maxv = (64'd1 << OUT_W) - 1;
    if (z) return 0;
    if (k >= OUT_W) return maxv;
    v = ((64'd1 << FRAC_W) + longint'(f)) << k;
`ifdef MITCHELL_ANTILOG_ROUND_EN
    r = (v + (64'd1 << (FRAC_W - 1))) >> FRAC_W;
`else
    r = v >> FRAC_W;
`endif
    if (r > maxv) r = maxv;
    return r;
  endfunction

  // Drive one operand, hold it until accepted, queue the expectation.
  // want < 0 means take the expected value from the reference model.
  task automatic send(input bit z, input int k, input int f, input longint want);
    int   n = 0;
    int   lat;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_zero  = z;
    in_char  = CHAR_W'(k);
    in_frac  = FRAC_W'(f);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk(1'b0, "accept_timeout", 0, 1);
    end else begin
      lat    = (z || k == 0 || k >= OUT_W) ? 0 : k;
      e.data = (want < 0) ? OUT_W'(model(z, k, f)) : OUT_W'(want);
      e.rise = cyc + 1 + lat;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(q.size() == 0, "drain_timeout", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor
  bit               prev_v = 1'b0;
  bit               hs_pend = 1'b0;
  logic [OUT_W-1:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v  = 1'b0;
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) begin
        chk(in_ready && !out_valid && !busy, "ready_after_handshake", {in_ready, out_valid}, 2'b10);
        hs_pend = 1'b0;
      end
      if (out_valid) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_result", out_data, 0);
          end else begin
            e = q.pop_front();
            chk(out_data == e.data, "result_data", out_data, e.data);
            chk(cyc == e.rise, "result_latency", cyc, e.rise);
          end
          held = out_data;
        end else begin
          chk(out_data == held, "hold_stable", out_data, held);
        end
        if (out_ready) hs_pend = 1'b1;
      end
      prev_v = out_valid;
    end
  end

  initial begin
    // Reset state while reset is held
    repeat (2) @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_data == '0, "rst_out_data", out_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    send(1'b0, 3, 'h4000, 12);
`ifdef MITCHELL_ANTILOG_ROUND_EN
    send(1'b0, 0, 'h7FFF, 2);
`else
    send(1'b0, 0, 'h7FFF, 1);
`endif
    send(1'b0, 31, 'h7FFF, 'hFFFF0000);
    send(1'b0, 4, 'h0800, 17);
    send(1'b1, 9, 'h1234, 0);
    send(1'b0, 40, 'h0123, 'hFFFFFFFF);
    send(1'b0, 32, 'h0000, 'hFFFFFFFF);
    send(1'b0, 1, 'h0000, 2);
    drain();

    // Backpressure: result held 5 cycles, a second operand waits meanwhile
    bp_mode = 1'b1;
    send(1'b0, 2, 'h0000, 4);
    fork
      send(1'b0, 3, 'h0000, 8);
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk(out_valid, "bp_valid_timeout", out_valid, 1);
        repeat (5) begin
          chk(!in_ready && out_valid, "bp_not_ready", {in_ready, out_valid}, 2'b01);
          @(negedge clk);
        end
        bp_mode = 1'b0;
      end
    join
    drain();

    // Reset in the middle of a shift
    @(negedge clk);
    in_valid = 1'b1;
    in_zero  = 1'b0;
    in_char  = CHAR_W'(20);
    in_frac  = FRAC_W'('h1111);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    chk(busy == 1'b1, "shift_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    chk(out_data == '0, "midrst_out_data", out_data, 0);
    chk(busy == 1'b0, "midrst_busy", busy, 0);
    chk(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 1, 'h0000, 2);
    drain();

    // Randomized operands with random consumer readiness
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      bit z;
      int k, f;
      z = ($urandom_range(0, 9) == 0);
      k = $urandom_range(0, 40);
      f = $urandom_range(0, (1 << FRAC_W) - 1);
      send(z, k, f, -1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
